// File: rtl/aidc_lite_code_split.sv
// AIDC-Lite block reader: fetches 8x64b words, strips the 2b prefix, presents a 66b MSB-first peek window; AIDC_LITE_CODE_SPLIT_PREFIX_CHECK_EN enables the prefix check.
// First window 5 cycles after start_i; consumes land on the next cycle's window; no read backpressure, valid_o drops during refill.
module aidc_lite_code_split #(
  parameter logic [1:0] PREFIX      = 2'b00,
  parameter int         WINDOW_SIZE = 66,
  parameter int         BUF_SIZE    = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   rd_o,
  output logic [2:0]             addr_o,
  input  logic [63:0]            rdata_i,
  output logic                   valid_o,
  output logic [WINDOW_SIZE-1:0] window_o,
  input  logic                   consume_i,
  input  logic [6:0]             size_i,
  input  logic                   eop_i,
  output logic                   done_o,
  output logic                   fail_o
);

`ifdef AIDC_LITE_CODE_SPLIT_PREFIX_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  localparam logic [7:0] WIN_W  = 8'(WINDOW_SIZE);
  localparam logic [6:0] MAX_SZ = 7'(WINDOW_SIZE);
  localparam logic [7:0] WORD_W = 8'd64;

  typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [BUF_SIZE-1:0] buf_q, buf_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;

  logic                active;
  logic                take;
  logic                overrun;
  logic                prefix_bad;
  logic [6:0]          sh;
  logic [7:0]          cnt_rem;
  logic [BUF_SIZE-1:0] shifted;

  always_comb begin
    active   = (state_q == S_PREFIX) || (state_q == S_RUN);
    rd_o     = active && !pend_q && (wcnt_q < 4'd8) && (cnt_q <= WORD_W) && !start_i;
    addr_o   = wcnt_q[2:0];
    valid_o  = (state_q == S_RUN) &&
               ((cnt_q >= WIN_W) || ((wcnt_q == 4'd8) && !pend_q && (cnt_q != 8'd0)));
    window_o = buf_q[BUF_SIZE-1 -: WINDOW_SIZE];
    done_o   = done_q;
    fail_o   = fail_q;

    take       = consume_i && valid_o;
    prefix_bad = (buf_q[BUF_SIZE-1 -: 2] != PREFIX);
    // Illegal sizes are folded into the overrun path so the block always terminates cleanly.
    overrun    = take && ((size_i == 7'd0) || (size_i > MAX_SZ) || ({1'b0, size_i} > cnt_q));

    sh = 7'd0;
    if ((state_q == S_PREFIX) && (cnt_q >= WORD_W)) begin
      sh = 7'd2;
    end else if (take) begin
      sh = size_i;
    end
    cnt_rem = overrun ? 8'd0 : (cnt_q - {1'b0, sh});
    shifted = overrun ? '0 : (buf_q << sh);

    state_d = state_q;
    buf_d   = shifted;
    cnt_d   = cnt_rem;
    wcnt_d  = wcnt_q;
    pend_d  = pend_q;
    err_d   = err_q;
    done_d  = done_q;
    fail_d  = fail_q;

    // Returning word lands directly behind whatever survives this cycle's shift.
    if (pend_q) begin
      pend_d = 1'b0;
      buf_d  = shifted | ({rdata_i, {(BUF_SIZE-64){1'b0}}} >> cnt_rem);
      cnt_d  = cnt_rem + WORD_W;
    end
    if (rd_o) begin
      wcnt_d = wcnt_q + 4'd1;
      pend_d = 1'b1;
    end

    case (state_q)
      S_PREFIX: begin
        if (cnt_q >= WORD_W) begin
          state_d = S_RUN;
          err_d   = err_q | (CHECK_EN & prefix_bad);
        end
      end
      S_RUN: begin
        if (overrun) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          fail_d  = 1'b1;
        end else if (take && eop_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          fail_d  = err_q;
        end else if (take && (wcnt_q == 4'd8) && !pend_q && (cnt_rem == 8'd0)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          fail_d  = 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // A new block wins over everything, including data returning for the old one.
    if (start_i) begin
      state_d = S_PREFIX;
      buf_d   = '0;
      cnt_d   = 8'd0;
      wcnt_d  = 4'd0;
      pend_d  = 1'b0;
      err_d   = 1'b0;
      done_d  = 1'b0;
      fail_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= 8'd0;
      wcnt_q  <= 4'd0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b1;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

endmodule

// File: tb/tb_aidc_lite_code_split.sv
// Bench for aidc_lite_code_split: random blocks and code sizes checked against a bit-position stream model.
module tb_aidc_lite_code_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        rd_o;
  logic [2:0]  addr_o;
  logic [63:0] rdata_i;
  logic        valid_o;
  logic [65:0] window_o;
  logic        consume_i;
  logic [6:0]  size_i;
  logic        eop_i;
  logic        done_o;
  logic        fail_o;

  int tests = 0;
  int fails = 0;

  logic [63:0]  mem [8];
  logic [511:0] stream;
  bit           pfx_bad;
  int           cons_q[$];
  int           eop_idx;

`ifdef AIDC_LITE_CODE_SPLIT_PREFIX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  aidc_lite_code_split dut (
    .clk(clk), .rst(rst), .start_i(start_i), .rd_o(rd_o), .addr_o(addr_o),
    .rdata_i(rdata_i), .valid_o(valid_o), .window_o(window_o), .consume_i(consume_i),
    .size_i(size_i), .eop_i(eop_i), .done_o(done_o), .fail_o(fail_o)
  );

  always #5 clk = ~clk;

  // Block memory: data one cycle after the request, junk otherwise.
  always @(posedge clk) rdata_i <= rd_o ? mem[addr_o] : {$urandom, $urandom};

  task automatic load_block(input logic [1:0] pfx);
    for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
    mem[0][63:62] = pfx;
    stream  = {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]};
    pfx_bad = (pfx != 2'b00);
  endtask

  // Window = stream bits after the prefix starting at pos, zero past the block end.
  function automatic logic [65:0] model_win(input int pos);
    logic [65:0] w;
    int p;
    for (int i = 0; i < 66; i++) begin
      p = 2 + pos + i;
      w[65-i] = (p < 512) ? stream[511-p] : 1'b0;
    end
    return w;
  endfunction

  task automatic gen_sizes(input bit with_eop);
    int rem, hi, s;
    cons_q.delete();
    rem = 510;
    while (rem > 0) begin
      hi = (rem < 66) ? rem : 66;
      s  = int'($urandom_range(1, hi));
      cons_q.push_back(s);
      rem -= s;
    end
    eop_idx = with_eop ? cons_q.size() - 1 : -1;
  endtask

  task automatic fill_sizes(input int n, input int s);
    cons_q.delete();
    for (int i = 0; i < n; i++) cons_q.push_back(s);
  endtask

  // stop_mode 0: run to termination; 1: return after seeing read of addr 3; 2: return after 5 consumes.
  task automatic run_block(input string name, input int stop_mode, input bit idle_en,
                           output bit finished, output bit exp_fail, output int nrd);
    int pos, k, first_rd, gap, max_gap, avail, rem, s;
    bit seen_valid, term_sent;
    logic [65:0] ew;
    pos = 0; k = 0; first_rd = -1; gap = 0; max_gap = 0;
    seen_valid = 0; term_sent = 0; finished = 0; exp_fail = 0; nrd = 0;
    consume_i = 0; eop_i = 0; size_i = 0; start_i = 1;
    #1;
    tests++;
    if (rd_o !== 1'b0) begin fails++; $display("FAIL %s rd_during_start: got %b want 0", name, rd_o); end
    for (int cyc = 1; cyc < 1000; cyc++) begin
      @(negedge clk);
      start_i = 0; consume_i = 0; eop_i = 0;
      #1;
      if (term_sent) begin finished = 1; break; end
      if (rd_o) begin
        avail = (nrd == 0) ? 0 : 64 * nrd - 2 - pos;
        if (first_rd < 0) begin
          first_rd = cyc;
          tests++;
          if (cyc != 1) begin fails++; $display("FAIL %s first_read_cycle: got %0d want 1", name, cyc); end
        end
        tests++;
        if (nrd > 7 || addr_o !== 3'(nrd)) begin
          fails++; $display("FAIL %s read_addr: got %0d want %0d", name, addr_o, nrd);
        end
        tests++;
        if (avail > 64) begin fails++; $display("FAIL %s read_while_full: buffered %0d want <=64", name, avail); end
        nrd++;
        if (stop_mode == 1 && addr_o == 3'd3) begin finished = 1; return; end
      end
      if (valid_o) begin
        ew = model_win(pos);
        tests++;
        if (window_o !== ew) begin
          fails++; $display("FAIL %s window pos=%0d: got %h want %h", name, pos, window_o, ew);
        end
        if (!seen_valid) begin
          tests++;
          if (done_o !== 1'b0) begin fails++; $display("FAIL %s done_while_run: got %b want 0", name, done_o); end
        end
        seen_valid = 1; gap = 0;
        if (stop_mode == 2 && k >= 5) begin finished = 1; return; end
        if (k < cons_q.size() && (!idle_en || $urandom_range(0, 3) != 0)) begin
          s = cons_q[k];
          rem = 510 - pos;
          assert (s >= 1 && s <= 66) else $error("illegal size_i %0d", s);
          consume_i = 1; size_i = 7'(s); eop_i = (k == eop_idx);
          if (s > rem) begin term_sent = 1; exp_fail = 1; end
          else if (k == eop_idx) begin term_sent = 1; exp_fail = CHK & pfx_bad; end
          else if (s == rem) begin term_sent = 1; exp_fail = 1; end
          pos += s; k++;
        end
      end else if (seen_valid) begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
    end
    consume_i = 0; eop_i = 0;
    tests++;
    if (!finished) begin fails++; $display("FAIL %s timeout: block did not terminate within budget", name); end
    tests++;
    if (max_gap > 2) begin fails++; $display("FAIL %s valid_gap: got %0d cycles want <=2", name, max_gap); end
  endtask

  task automatic test_reset;
    rst = 1; start_i = 0; consume_i = 0; size_i = 0; eop_i = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk); #1;
    tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL reset_done: got %b want 1", done_o); end
    tests++; if (fail_o !== 1'b0) begin fails++; $display("FAIL reset_fail: got %b want 0", fail_o); end
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    tests++; if (rd_o !== 1'b0) begin fails++; $display("FAIL reset_rd: got %b want 0", rd_o); end
    tests++; if (addr_o !== 3'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", addr_o); end
    tests++; if (window_o !== 66'd0) begin fails++; $display("FAIL reset_window: got %h want 0", window_o); end
  endtask

  task automatic finish_checks(input string name, input bit finished, input bit exp_fail,
                               input int nrd, input int exp_nrd);
    tests++; if (!finished) begin fails++; $display("FAIL %s finished: got 0 want 1", name); end
    tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL %s done: got %b want 1", name, done_o); end
    tests++; if (fail_o !== exp_fail) begin fails++; $display("FAIL %s fail: got %b want %b", name, fail_o, exp_fail); end
    tests++; if (nrd != exp_nrd) begin fails++; $display("FAIL %s read_count: got %0d want %0d", name, nrd, exp_nrd); end
  endtask

  task automatic test_fixed17;
    bit fin, ef; int nrd;
    load_block(2'b00);
    fill_sizes(30, 17); eop_idx = 29;
    run_block("fixed17", 0, 0, fin, ef, nrd);
    finish_checks("fixed17", fin, ef, nrd, 8);
  endtask

  task automatic test_max66;
    bit fin, ef; int nrd;
    load_block(2'b00);
    fill_sizes(7, 66); cons_q.push_back(48); eop_idx = 7;
    run_block("max66", 0, 0, fin, ef, nrd);
    finish_checks("max66", fin, ef, nrd, 8);
  endtask

  task automatic test_overrun;
    bit fin, ef; int nrd;
    load_block(2'b00);
    fill_sizes(26, 20); eop_idx = -1;
    run_block("overrun", 0, 0, fin, ef, nrd);
    finish_checks("overrun", fin, ef, nrd, 8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      tests++;
      if (rd_o !== 1'b0 || valid_o !== 1'b0 || done_o !== 1'b1 || fail_o !== 1'b1) begin
        fails++; $display("FAIL overrun_hold: rd=%b valid=%b done=%b fail=%b want 0 0 1 1", rd_o, valid_o, done_o, fail_o);
      end
    end
  endtask

  task automatic test_prefix_err;
    bit fin, ef; int nrd;
    load_block(2'b11);
    gen_sizes(1);
    run_block("prefix_err", 0, 1, fin, ef, nrd);
    finish_checks("prefix_err", fin, ef, nrd, 8);
  endtask

  task automatic test_random;
    bit fin, ef; int nrd;
    for (int b = 0; b < 6; b++) begin
      load_block(2'b00);
      gen_sizes(b % 3 != 1);
      if (b % 3 == 2) eop_idx = int'($urandom_range(0, cons_q.size() - 1));
      run_block("random", 0, b[0], fin, ef, nrd);
      finish_checks("random", fin, ef, nrd, (b % 3 == 2) ? nrd : 8);
    end
  endtask

  task automatic test_back_to_back_abort;
    bit fin, ef; int nrd;
    load_block(2'b00);
    gen_sizes(1);
    run_block("abort_old", 1, 0, fin, ef, nrd);
    tests++; if (!fin) begin fails++; $display("FAIL abort_reach_addr3: got 0 want 1"); end
    @(negedge clk);
    load_block(2'b00);
    gen_sizes(1);
    run_block("abort_new", 0, 0, fin, ef, nrd);
    finish_checks("abort_new", fin, ef, nrd, 8);
  endtask

  task automatic test_rst_mid;
    bit fin, ef; int nrd;
    load_block(2'b00);
    gen_sizes(1);
    run_block("rst_mid", 2, 0, fin, ef, nrd);
    tests++; if (!fin) begin fails++; $display("FAIL rst_mid_reach_run: got 0 want 1"); end
    rst = 1; consume_i = 0;
    @(negedge clk); #1;
    tests++;
    if (done_o !== 1'b1 || fail_o !== 1'b0 || valid_o !== 1'b0 || rd_o !== 1'b0 || window_o !== 66'd0) begin
      fails++; $display("FAIL rst_mid_state: done=%b fail=%b valid=%b rd=%b window=%h want 1 0 0 0 0",
                        done_o, fail_o, valid_o, rd_o, window_o);
    end
    rst = 0;
    @(negedge clk); #1;
    tests++; if (rd_o !== 1'b0) begin fails++; $display("FAIL rst_mid_idle_rd: got %b want 0", rd_o); end
  endtask

  initial begin
    rst = 1; start_i = 0; consume_i = 0; size_i = 0; eop_i = 0;
    test_reset;
    test_fixed17;
    test_max66;
    test_overrun;
    test_prefix_err;
    test_random;
    test_back_to_back_abort;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
